ctrl_sweep_seq: RTL and testbench

//  Sequencer for the 4-bit control input of the case-decoder (ttcase) datapath.

---
 rtl/dds_ctrl_pkg.sv | 7 +
 rtl/ctrl_sweep_seq_if.sv | 29 ++
 rtl/ctrl_sweep_seq_dwell_timer.sv | 21 ++
 rtl/ctrl_sweep_seq.sv | 111 +++++++++++
 tb/tb_ctrl_sweep_seq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the ctrl sweep sequencer.
package dds_ctrl_pkg;
  localparam int CTRL_W_DEF  = 4;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_ADV, S_DONE} state_e;
endpackage

// File: rtl/ctrl_sweep_seq_if.sv
// Host/decoder-facing bundle of the sweep sequencer.
interface ctrl_sweep_seq_if #(
  parameter int CTRL_W  = 4,
  parameter int DWELL_W = 8
);
  logic              start;
  logic              stop;
  logic [CTRL_W-1:0] cfg_first;
  logic [CTRL_W-1:0] cfg_last;
  logic [CTRL_W-1:0] cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic              cfg_loop;
  logic [CTRL_W-1:0] lut_in;
  logic [CTRL_W-1:0] ctrl;
  logic              busy;
  logic [CTRL_W-1:0] sample_data;
  logic              sample_valid;
  logic              done;
  logic              err;

  modport slave (
    input  start, stop, cfg_first, cfg_last, cfg_step, cfg_dwell, cfg_loop, lut_in,
    output ctrl, busy, sample_data, sample_valid, done, err
  );
  modport master (
    output start, stop, cfg_first, cfg_last, cfg_step, cfg_dwell, cfg_loop, lut_in,
    input  ctrl, busy, sample_data, sample_valid, done, err
  );
endinterface

// File: rtl/ctrl_sweep_seq_dwell_timer.sv
// Per-code hold counter: loads the dwell value, counts down, flags zero.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/ctrl_sweep_seq.sv
// Steps the decoder ctrl code from first to last with step/dwell, sampling lut_in per code.
module ctrl_sweep_seq
  import dds_ctrl_pkg::*;
#(
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_sweep_seq_if.slave   bus
);
  state_e             r_state;
  logic [CTRL_W-1:0]  r_first, r_last, r_step, r_ctrl, r_sample_data;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_loop, r_busy, r_sample_valid, r_done, r_err;

  logic               w_accept, w_adv_go, w_load, w_dec, w_zero;
  logic [DWELL_W-1:0] w_load_val;
  logic [CTRL_W:0]    w_nxt;

  // One extra bit so an overflowing code reads as past-the-end instead of wrapping.
  assign w_nxt      = {1'b0, r_ctrl} + {1'b0, r_step};
  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.stop &&
                      (bus.cfg_first <= bus.cfg_last);
  assign w_adv_go   = (r_state == S_ADV) && !bus.stop &&
                      ((w_nxt <= {1'b0, r_last}) || r_loop);
  assign w_load     = w_accept || w_adv_go;
  assign w_load_val = w_accept ? bus.cfg_dwell : r_dwell;
  assign w_dec      = (r_state == S_DWELL) && !bus.stop;

  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_first        <= '0;
      r_last         <= '0;
      r_step         <= '0;
      r_dwell        <= '0;
      r_loop         <= 1'b0;
      r_ctrl         <= '0;
      r_busy         <= 1'b0;
      r_sample_data  <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start && !bus.stop) begin
          if (bus.cfg_first <= bus.cfg_last) begin
            r_first <= bus.cfg_first;
            r_last  <= bus.cfg_last;
            r_step  <= (bus.cfg_step == '0) ? CTRL_W'(1) : bus.cfg_step;
            r_dwell <= bus.cfg_dwell;
            r_loop  <= bus.cfg_loop;
            r_ctrl  <= bus.cfg_first;
            r_busy  <= 1'b1;
            r_state <= S_DWELL;
          end else begin
            r_err   <= 1'b1;
          end
        end
        S_DWELL: begin
          if (bus.stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_zero) begin
            r_sample_data  <= bus.lut_in;
            r_sample_valid <= 1'b1;
            r_state        <= S_ADV;
          end
        end
        S_ADV: begin
          if (bus.stop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_nxt <= {1'b0, r_last}) begin
            r_ctrl  <= w_nxt[CTRL_W-1:0];
            r_state <= S_DWELL;
          end else if (r_loop) begin
            r_ctrl  <= r_first;
            r_state <= S_DWELL;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ctrl         = r_ctrl;
  assign bus.busy         = r_busy;
  assign bus.sample_data  = r_sample_data;
  assign bus.sample_valid = r_sample_valid;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
endmodule

// File: tb/tb_ctrl_sweep_seq.sv
// Scoreboarded random/directed bench for ctrl_sweep_seq with a stand-in decoder on ctrl/lut_in.
module tb_ctrl_sweep_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_ctrl = 0;
  bit   mon_en = 1'b0;

  typedef struct { int kind; int code; int data; int cyc; } ev_t;  // kind: 0 sample, 1 done, 2 err
  ev_t q[$];

  ctrl_sweep_seq_if #(.CTRL_W(4), .DWELL_W(8)) bus ();

  ctrl_sweep_seq #(.CTRL_W(4), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [3:0] ttcase(input logic [3:0] c);
    return {c[0], c[3:1]} ^ 4'h6;
  endfunction

  assign bus.lut_in = ttcase(bus.ctrl);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the next expected event in cycle, kind, ctrl and data.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.sample_valid || bus.done || bus.err) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk("unexpected_pulse", {bus.err, bus.done, bus.sample_valid}, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {bus.err, bus.done, bus.sample_valid}, 1 << e.kind);
          chk("pulse_ctrl", bus.ctrl, e.code);
          if (e.kind == 0) chk("sample_data", bus.sample_data, e.data);
        end
      end
    end
  end

  // Reference: a sweep is the list of codes first, first+step, ... <= last (repeating if looping);
  // each code lasts dwell+2 cycles and its sample appears after dwell+1 of them.
  task automatic sweep(input int f, input int l, input int s, input int d, input int lp,
                       input int stop_after, input int use_rst, input int noise);
    int P, per, n, S, k, se, c, start_lim;
    int codes[$];
    bus.cfg_first = 4'(f);
    bus.cfg_last  = 4'(l);
    bus.cfg_step  = 4'(s);
    bus.cfg_dwell = 8'(d);
    bus.cfg_loop  = (lp != 0);
    bus.start     = 1'b1;
    P = cyc + 1;
    if (f > l) begin
      q.push_back('{2, m_ctrl, 0, P});
      @(negedge clk);
      bus.start = 1'b0;
      chk("err_busy", bus.busy, 0);
      chk("err_ctrl_hold", bus.ctrl, m_ctrl);
      return;
    end
    se  = (s == 0) ? 1 : s;
    per = d + 2;
    if (lp != 0) begin
      c = f;
      repeat (64) begin
        codes.push_back(c);
        c = c + se;
        if (c > l) c = f;
      end
    end else begin
      for (c = f; c <= l; c += se) codes.push_back(c);
    end
    n = codes.size();
    for (int i = 0; i < n; i++)
      q.push_back('{0, codes[i], int'(ttcase(4'(codes[i]))), P + i*per + d + 1});
    if (lp == 0) q.push_back('{1, codes[n-1], 0, P + n*per});
    S         = (stop_after > 0) ? P + stop_after : P + n*per + 2;
    start_lim = (stop_after > 0) ? S - 1 : P + n*per + 1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_ctrl", bus.ctrl, f);
    while (cyc + 1 < S) begin
      if (noise != 0) begin
        bus.cfg_first = 4'($urandom_range(0, 15));
        bus.cfg_last  = 4'($urandom_range(0, 15));
        bus.cfg_step  = 4'($urandom_range(0, 15));
        bus.cfg_dwell = 8'($urandom_range(0, 255));
        bus.cfg_loop  = 1'($urandom_range(0, 1));
        bus.start     = (cyc + 1 <= start_lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (stop_after > 0) begin
      if (use_rst != 0) rst_n = 1'b0;
      else              bus.stop = 1'b1;
      while (q.size() > 0 && q[$].cyc >= S) void'(q.pop_back());
      k = (S - 1 - P) / per;
      if (lp == 0 && k > n - 1) k = n - 1;
      m_ctrl = (use_rst != 0) ? 0 : codes[k];
      @(negedge clk);
      bus.stop = 1'b0;
      rst_n    = 1'b1;
      chk("halt_busy", bus.busy, 0);
      chk("halt_ctrl", bus.ctrl, m_ctrl);
      if (use_rst != 0) begin
        chk("rst_sample_data", bus.sample_data, 0);
        chk("rst_pulses", {bus.err, bus.done, bus.sample_valid}, 0);
      end
    end else begin
      m_ctrl = codes[n-1];
      chk("end_busy", bus.busy, 0);
      chk("end_ctrl", bus.ctrl, m_ctrl);
    end
  endtask

  initial begin
    int f, l, s, d, lp, sa, ur, n, se;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.cfg_first = '0; bus.cfg_last = '0; bus.cfg_step = '0;
    bus.cfg_dwell = '0; bus.cfg_loop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", bus.ctrl, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_sample_data", bus.sample_data, 0);
    chk("reset_pulses", {bus.err, bus.done, bus.sample_valid}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    sweep(2, 8, 3, 1, 0, 0, 0, 0);    // codes 2,5,8
    sweep(14, 15, 3, 0, 0, 0, 0, 0);  // 14+3 overflows: single code
    sweep(0, 3, 0, 0, 1, 13, 0, 0);   // looping, step 0 -> 1, then stop
    sweep(9, 4, 0, 0, 0, 0, 0, 0);    // rejected start
    sweep(1, 12, 2, 1, 0, 9, 1, 1);   // cfg/start noise while busy, then reset

    // start and stop together in IDLE: nothing happens
    bus.cfg_first = 4'd1; bus.cfg_last = 4'd5; bus.cfg_step = 4'd1; bus.cfg_dwell = 8'd0;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_busy", bus.busy, 0);
    @(negedge clk);
    chk("start_stop_ctrl", bus.ctrl, m_ctrl);

    sweep(1, 7, 2, 2, 0, 16, 0, 0);   // stop lands in ADV of final code: no done

    for (int it = 0; it < 30; it++) begin
      f = $urandom_range(0, 15);
      l = $urandom_range(0, 15);
      if (it % 3 != 2 && f > l) begin n = f; f = l; l = n; end
      s  = $urandom_range(0, 4);
      d  = $urandom_range(0, 3);
      lp = ($urandom_range(0, 3) == 0) ? 1 : 0;
      se = (s == 0) ? 1 : s;
      n  = (f <= l) ? (l - f) / se + 1 : 1;
      if (lp != 0) sa = $urandom_range(1, 40);
      else         sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * (d + 2)) : 0;
      ur = (sa > 0 && $urandom_range(0, 4) == 0) ? 1 : 0;
      sweep(f, l, s, d, lp, sa, ur, 1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
